// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: per-source forwarding selects,
// multi-cycle load-use stall FSM and branch flush. Optional perf counters via HAZ_PERF_CNT_EN.
module hazard_fwd_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned PERF_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        ex_rf_en,
  input  logic                        ex_load,
  input  logic [REG_AW-1:0]           mem_rd,
  input  logic                        mem_rf_en,
  input  logic [REG_AW-1:0]           wb_rd,
  input  logic                        wb_rf_en,
  input  logic                        branch_taken,
  output logic [NUM_SRC*2-1:0]        fwd_sel,
  output logic                        pc_le,
  output logic                        ifid_le,
  output logic                        ctrl_bubble,
  output logic                        ifid_flush,
  output logic                        stall_active,
  output logic [PERF_W-1:0]           perf_stalls,
  output logic [PERF_W-1:0]           perf_flushes
);

  localparam int unsigned CNT_W = 3;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 hazard;
  logic [NUM_SRC*2-1:0] fwd_raw;
  logic [REG_AW-1:0]    src;
  logic [1:0]           sel;

  // Per-source forwarding select and load-use detection; register 0 never matches
  always_comb begin
    fwd_raw = '0;
    hazard  = 1'b0;
    src     = '0;
    sel     = FWD_RF;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src = id_src[i*REG_AW +: REG_AW];
      sel = FWD_RF;
      if (id_src_used[i] && (src != '0)) begin
        if (ex_rf_en && !ex_load && (src == ex_rd)) begin
          sel = FWD_EX;
        end else if (mem_rf_en && (src == mem_rd)) begin
          sel = FWD_MEM;
        end else if (wb_rf_en && (src == wb_rd)) begin
          sel = FWD_WB;
        end
        if (ex_load && ex_rf_en && (src == ex_rd)) begin
          hazard = 1'b1;
        end
      end
      fwd_raw[i*2 +: 2] = sel;
    end
  end

  // Next-state and pipeline-control outputs; flush overrides any stall
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    fwd_sel      = fwd_raw;
    pc_le        = 1'b1;
    ifid_le      = 1'b1;
    ctrl_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    stall_active = 1'b0;

    if (!reset_n) begin
      state_nxt   = S_IDLE;
      cnt_nxt     = '0;
      fwd_sel     = '0;
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      ctrl_bubble = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (hazard) begin
            pc_le       = 1'b0;
            ifid_le     = 1'b0;
            ctrl_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = S_STALL;
              cnt_nxt   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        S_STALL: begin
          // EX already holds a bubble here, so fresh hazards are not re-examined
          pc_le        = 1'b0;
          ifid_le      = 1'b0;
          ctrl_bubble  = 1'b1;
          stall_active = 1'b1;
          cnt_nxt      = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase

      if (branch_taken) begin
        ifid_flush  = 1'b1;
        ctrl_bubble = 1'b1;
        pc_le       = 1'b1;
        ifid_le     = 1'b1;
        state_nxt   = S_IDLE;
        cnt_nxt     = '0;
      end
    end
  end

  // State and stall counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stalls_q;
  logic [PERF_W-1:0] flushes_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (ctrl_bubble && !ifid_flush && (stalls_q != '1)) begin
        stalls_q <= stalls_q + PERF_W'(1);
      end
      if (ifid_flush && (flushes_q != '1)) begin
        flushes_q <= flushes_q + PERF_W'(1);
      end
    end
  end

  assign perf_stalls  = stalls_q;
  assign perf_flushes = flushes_q;
`else
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding priority, load-use stall for
// LOAD_LAT=1 and LOAD_LAT=3, branch flush and reset behaviour.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_rf_en, ex_load, mem_rf_en, wb_rf_en, branch_taken;

  logic [3:0]  fwd1, fwd3;
  logic        pc1, ifid1, bub1, fl1, st1;
  logic        pc3, ifid3, bub3, fl3, st3;
  logic [15:0] ps1, pf1, ps3, pf3;

  int n_checks = 0;
  int n_errors = 0;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .PERF_W(16)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .id_src(id_src), .id_src_used(id_src_used),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .branch_taken(branch_taken), .fwd_sel(fwd1), .pc_le(pc1), .ifid_le(ifid1),
    .ctrl_bubble(bub1), .ifid_flush(fl1), .stall_active(st1),
    .perf_stalls(ps1), .perf_flushes(pf1)
  );

  hazard_fwd_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .PERF_W(16)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .id_src(id_src), .id_src_used(id_src_used),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .branch_taken(branch_taken), .fwd_sel(fwd3), .pc_le(pc3), .ifid_le(ifid3),
    .ctrl_bubble(bub3), .ifid_flush(fl3), .stall_active(st3),
    .perf_stalls(ps3), .perf_flushes(pf3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    id_src = '0; id_src_used = '0;
    ex_rd = '0; ex_rf_en = 1'b0; ex_load = 1'b0;
    mem_rd = '0; mem_rf_en = 1'b0; wb_rd = '0; wb_rf_en = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    set_idle();
    step();
    reset_n = 1'b1;
  endtask

  // Load in EX writing r5, src1=r5 used
  task automatic load_use();
    set_idle();
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd5;
    id_src = {5'd5, 5'd9}; id_src_used = 2'b10;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with matching sources and branch asserted: all outputs held inactive
    set_idle();
    reset_n = 1'b0;
    id_src = {5'd4, 5'd3}; id_src_used = 2'b11;
    ex_rd = 5'd3; ex_rf_en = 1'b1; branch_taken = 1'b1;
    step(); settle();
    check("rst_pc_le", 32'(pc3), 32'd0);
    check("rst_ifid_le", 32'(ifid3), 32'd0);
    check("rst_bubble", 32'(bub3), 32'd1);
    check("rst_flush", 32'(fl3), 32'd0);
    check("rst_fwd", 32'(fwd3), 32'd0);
    check("rst_stall", 32'(st3), 32'd0);

    step();
    reset_n = 1'b1; set_idle(); settle();
    check("idle_pc_le", 32'(pc3), 32'd1);
    check("idle_bubble", 32'(bub3), 32'd0);
    check("idle_perf_stalls", 32'(ps3), 32'd0);

    // EX > MEM priority: src0=3 from EX, src1=4 from MEM
    id_src = {5'd4, 5'd3}; id_src_used = 2'b11;
    ex_rd = 5'd3; ex_rf_en = 1'b1;
    mem_rd = 5'd4; mem_rf_en = 1'b1; wb_rd = 5'd4; wb_rf_en = 1'b1;
    settle();
    check("fwd_ex_mem", 32'(fwd3), 32'b1001);
    check("fwd_pc_le", 32'(pc3), 32'd1);
    check("fwd_no_bubble", 32'(bub3), 32'd0);

    // No source used: no forwarding despite matches
    id_src_used = 2'b00; settle();
    check("fwd_unused", 32'(fwd3), 32'b0000);

    // r0 never forwarded
    set_idle();
    id_src = {5'd0, 5'd0}; id_src_used = 2'b01; ex_rd = 5'd0; ex_rf_en = 1'b1;
    settle();
    check("fwd_r0", 32'(fwd3), 32'b0000);

    // WB only
    set_idle();
    id_src = {5'd0, 5'd7}; id_src_used = 2'b11; wb_rd = 5'd7; wb_rf_en = 1'b1;
    settle();
    check("fwd_wb", 32'(fwd3), 32'b0011);

    // EX not writing: falls back to MEM
    set_idle();
    id_src = {5'd3, 5'd0}; id_src_used = 2'b10;
    ex_rd = 5'd3; mem_rd = 5'd3; mem_rf_en = 1'b1; wb_rd = 5'd3; wb_rf_en = 1'b1;
    settle();
    check("fwd_ex_off", 32'(fwd3), 32'b1000);

    // Load in EX is never forwarded from EX
    set_idle();
    id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
    ex_rd = 5'd3; ex_rf_en = 1'b1; ex_load = 1'b1; mem_rd = 5'd3; mem_rf_en = 1'b1;
    settle();
    check("fwd_load_skip", 32'(fwd3), 32'b0010);

    // Load with no dependent source / dependency via unused source
    set_idle();
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd6;
    id_src = {5'd6, 5'd2}; id_src_used = 2'b01;
    settle();
    check("load_nodep_pc", 32'(pc3), 32'd1);
    check("load_nodep_fwd", 32'(fwd3), 32'b0000);

    // LOAD_LAT=1: one bubble cycle, then MEM forward
    reset_pulse();
    load_use(); settle();
    check("lat1_pc_le", 32'(pc1), 32'd0);
    check("lat1_ifid_le", 32'(ifid1), 32'd0);
    check("lat1_bubble", 32'(bub1), 32'd1);
    step();
    set_idle();
    id_src = {5'd5, 5'd9}; id_src_used = 2'b10; mem_rd = 5'd5; mem_rf_en = 1'b1;
    settle();
    check("lat1_after_fwd", 32'(fwd1), 32'b1000);
    check("lat1_after_pc", 32'(pc1), 32'd1);
    check("lat1_after_bub", 32'(bub1), 32'd0);
    check("lat1_stall", 32'(st1), 32'd0);

    // LOAD_LAT=3: three bubbles, stall_active on the last two; hazard kept to show it is ignored
    reset_pulse();
    load_use(); settle();
    check("lat3_c1_bub", 32'(bub3), 32'd1);
    check("lat3_c1_pc", 32'(pc3), 32'd0);
    check("lat3_c1_stall", 32'(st3), 32'd0);
    step(); settle();
    check("lat3_c2_bub", 32'(bub3), 32'd1);
    check("lat3_c2_stall", 32'(st3), 32'd1);
    check("lat3_c2_ifid", 32'(ifid3), 32'd0);
    step(); settle();
    check("lat3_c3_bub", 32'(bub3), 32'd1);
    check("lat3_c3_stall", 32'(st3), 32'd1);
    step();
    set_idle();
    id_src = {5'd5, 5'd9}; id_src_used = 2'b10; mem_rd = 5'd5; mem_rf_en = 1'b1;
    settle();
    check("lat3_c4_bub", 32'(bub3), 32'd0);
    check("lat3_c4_stall", 32'(st3), 32'd0);
    check("lat3_c4_pc", 32'(pc3), 32'd1);
    check("lat3_c4_fwd", 32'(fwd3), 32'b1000);
    check("lat3_perf_stalls", 32'(ps3), PERF_ON ? 32'd3 : 32'd0);

    // Branch on first STALL cycle aborts the stall
    reset_pulse();
    load_use(); step();
    set_idle(); branch_taken = 1'b1; settle();
    check("br_flush", 32'(fl3), 32'd1);
    check("br_pc_le", 32'(pc3), 32'd1);
    check("br_ifid_le", 32'(ifid3), 32'd1);
    check("br_bubble", 32'(bub3), 32'd1);
    step();
    branch_taken = 1'b0; settle();
    check("br_next_stall", 32'(st3), 32'd0);
    check("br_next_bub", 32'(bub3), 32'd0);
    check("br_perf_stalls", 32'(ps3), PERF_ON ? 32'd1 : 32'd0);
    check("br_perf_flushes", 32'(pf3), PERF_ON ? 32'd1 : 32'd0);
    step(); settle();
    check("br_later_bub", 32'(bub3), 32'd0);

    // Branch together with hazard in IDLE: flush wins, no STALL
    reset_pulse();
    load_use(); branch_taken = 1'b1; settle();
    check("brhz_flush", 32'(fl3), 32'd1);
    check("brhz_pc_le", 32'(pc3), 32'd1);
    step();
    set_idle(); settle();
    check("brhz_stall", 32'(st3), 32'd0);
    check("brhz_bub", 32'(bub3), 32'd0);

    // Reset asserted during STALL
    reset_pulse();
    load_use(); step(); settle();
    check("rs_in_stall", 32'(st3), 32'd1);
    reset_n = 1'b0; settle();
    check("rs_pc_le", 32'(pc3), 32'd0);
    check("rs_bubble", 32'(bub3), 32'd1);
    check("rs_stall", 32'(st3), 32'd0);
    step();
    reset_n = 1'b1; set_idle(); settle();
    check("rs_after_stall", 32'(st3), 32'd0);
    check("rs_after_bub", 32'(bub3), 32'd0);
    check("rs_after_pc", 32'(pc3), 32'd1);
    check("rs_perf_stalls", 32'(ps3), 32'd0);
    check("rs_perf_flushes", 32'(pf3), 32'd0);
    step(); settle();
    check("rs_idle_hold", 32'(st3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
